enc_stage_2: RTL

Second and final stage of the multi-mode Hamming encoder pipeline. It consumes the partial codeword from stage 1, which has its overall-parity slot set to 0. It computes the overall (even) parity bit and inserts it into that slot. Completed codewords are buffered in a 2-entry FIFO behind a valid/ready handshake toward the channel/transmit logic. Malformed inputs are rejected, and the block keeps throughput and error counters.

---
 rtl/enc_stage_2.sv | 129 ++++++++++++
 1 files changed

// File: rtl/enc_stage_2.sv
// Final Hamming encoder stage: inserts overall even parity, rejects malformed words,
// and buffers completed codewords in a 2-entry FIFO with throughput/error counters.
module enc_stage_2 #(
  parameter int MAX_CODEWORD_WIDTH = 32,
  parameter int MAX_INFO_WIDTH     = 26
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [MAX_CODEWORD_WIDTH-1:0] data_in,
  input  logic [1:0]                    mod,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [MAX_CODEWORD_WIDTH-1:0] data_out,
  output logic [1:0]                    out_mod,
  output logic                          err_pulse,
  output logic [15:0]                   cw_count,
  output logic [7:0]                    err_count
);

  localparam int CW = MAX_CODEWORD_WIDTH;
  localparam int IW = $clog2(CW);

  logic [CW-1:0] mem_q [2];
  logic [CW-1:0] mem_d [2];
  logic [1:0]    mmod_q [2];
  logic [1:0]    mmod_d [2];
  logic          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0]    count_q, count_d;
  logic [CW-1:0] data_out_q, data_out_d;
  logic [1:0]    out_mod_q, out_mod_d;
  logic          err_pulse_q, err_pulse_d;
  logic [15:0]   cw_count_q, cw_count_d;
  logic [7:0]    err_count_q, err_count_d;

  logic [CW-1:0] mask;
  logic [IW-1:0] p_idx;
  logic          parity, legal, accept, push, pop;
  logic [CW-1:0] stored;

  always_comb begin
    mask  = '0;
    p_idx = '0;
    case (mod)
      2'b00: begin mask = CW'(8'hFF);   p_idx = IW'(3); end
      2'b01: begin mask = CW'(16'hFFFF); p_idx = IW'(4); end
      2'b10: begin mask = {CW{1'b1}} >> (CW - MAX_INFO_WIDTH - 6); p_idx = IW'(5); end
      default: begin mask = '0; p_idx = '0; end
    endcase
  end

  assign parity = ^(data_in & mask);
  assign stored = data_in | (CW'(parity) << p_idx);
  assign legal  = (mod != 2'b11) && !data_in[p_idx] && ((data_in & ~mask) == '0);

  // in_ready depends only on registered occupancy, never on out_ready
  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign accept    = in_valid && in_ready;
  assign push      = accept && legal;
  assign pop       = out_valid && out_ready;

  always_comb begin
    mem_d       = mem_q;
    mmod_d      = mmod_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    cw_count_d  = cw_count_q;
    err_count_d = err_count_q;
    err_pulse_d = accept && !legal;
    if (push) begin
      mem_d[wr_ptr_q]  = stored;
      mmod_d[wr_ptr_q] = mod;
      wr_ptr_d         = !wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d   = !rd_ptr_q;
      cw_count_d = cw_count_q + 16'd1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
    if (accept && !legal && err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
    // Output registers track the next head; they hold their last value when empty
    data_out_d = data_out_q;
    out_mod_d  = out_mod_q;
    if (count_d != 2'd0) begin
      data_out_d = mem_d[rd_ptr_d];
      out_mod_d  = mmod_d[rd_ptr_d];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q       <= '{default: '0};
      mmod_q      <= '{default: '0};
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
      data_out_q  <= '0;
      out_mod_q   <= 2'b00;
      err_pulse_q <= 1'b0;
      cw_count_q  <= 16'd0;
      err_count_q <= 8'd0;
    end else begin
      mem_q       <= mem_d;
      mmod_q      <= mmod_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      data_out_q  <= data_out_d;
      out_mod_q   <= out_mod_d;
      err_pulse_q <= err_pulse_d;
      cw_count_q  <= cw_count_d;
      err_count_q <= err_count_d;
    end
  end

  assign data_out  = data_out_q;
  assign out_mod   = out_mod_q;
  assign err_pulse = err_pulse_q;
  assign cw_count  = cw_count_q;
  assign err_count = err_count_q;

endmodule
